// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - states, init defaults, bus polarity and per-state bus decode for the RTC controller
package rtc_bus_pkg;

  localparam logic [7:0] INIT_ADDR_DEF = 8'h02;
  localparam logic [7:0] INIT_V0_DEF   = 8'h10;
  localparam logic [7:0] INIT_V1_DEF   = 8'h00;

  localparam logic CS_ON   = 1'b0;
  localparam logic CS_OFF  = 1'b1;
  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;
  localparam logic AD_ADDR = 1'b0;
  localparam logic AD_DATA = 1'b1;

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_IDLE,
    S_ADDR, S_AWR, S_AHOLD, S_GAP, S_DSET, S_DSTB, S_DHOLD, S_DONE
  } state_e;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       oe;
    logic [7:0] ad;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs_n: CS_OFF, rd_n: STB_OFF, wr_n: STB_OFF,
                                a_d: AD_ADDR, oe: 1'b0, ad: 8'h00};

  // Read cycles never enable the driver, so RD_n low and AD_oe high cannot coincide.
  function automatic bus_t bus_decode(input state_e st, input logic wr,
                                      input logic [7:0] addr, input logic [7:0] data);
    bus_t b;
    b = BUS_IDLE;
    case (st)
      S_ADDR, S_AWR, S_AHOLD: begin
        b.cs_n = CS_ON;
        b.oe   = 1'b1;
        b.ad   = addr;
        if (st == S_AWR) b.wr_n = STB_ON;
      end
      S_DSET, S_DSTB, S_DHOLD: begin
        b.cs_n = CS_ON;
        b.a_d  = AD_DATA;
        b.oe   = wr;
        b.ad   = wr ? data : 8'h00;
        if (st == S_DSTB) begin
          if (wr) b.wr_n = STB_ON;
          else    b.rd_n = STB_ON;
        end
      end
      default: b = BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable 8-bit down-counter timing each bus phase
module rtc_phase_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] len_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  // Loading len-1 makes done_o assert during the last cycle of a len-cycle phase.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = len_i - 8'd1;
    else if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_controller.sv
// rtl/rtc_bus_controller.sv - menu-side responder running timed multiplexed RTC bus cycles and init sequence
module rtc_bus_controller
  import rtc_bus_pkg::*;
#(
  parameter int         T_SETUP   = 2,
  parameter int         T_PULSE   = 4,
  parameter int         T_HOLD    = 2,
  parameter logic [7:0] INIT_ADDR = INIT_ADDR_DEF,
  parameter logic [7:0] INIT_V0   = INIT_V0_DEF,
  parameter logic [7:0] INIT_V1   = INIT_V1_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Acceso,
  input  logic [6:0] Dir,
  input  logic       Mod,
  input  logic [7:0] Dato_wr,
  output logic       FRW,
  output logic [7:0] Dato_rd,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  input  logic [7:0] AD_in
);

  localparam logic [7:0] LEN_SETUP = 8'(T_SETUP);
  localparam logic [7:0] LEN_PULSE = 8'(T_PULSE);
  localparam logic [7:0] LEN_HOLD  = 8'(T_HOLD);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d, data_q, data_d;
  logic       wr_q, wr_d, init0_q, init0_d;
  logic       frw_q;
  logic [7:0] dato_rd_q;
  bus_t       bus_q;
  logic       tmr_load, tmr_done;
  logic [7:0] tmr_len;

  rtc_phase_timer u_timer (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (tmr_load),
    .len_i  (tmr_len),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    init0_d = init0_q;
    case (state_q)
      S_INIT0: begin
        addr_d = INIT_ADDR; data_d = INIT_V0; wr_d = 1'b1; init0_d = 1'b1; state_d = S_ADDR;
      end
      S_INIT1: begin
        addr_d = INIT_ADDR; data_d = INIT_V1; wr_d = 1'b1; init0_d = 1'b0; state_d = S_ADDR;
      end
      S_IDLE: if (Acceso) begin
        addr_d = {1'b0, Dir}; data_d = Dato_wr; wr_d = Mod; state_d = S_ADDR;
      end
      S_ADDR:  if (tmr_done) state_d = S_AWR;
      S_AWR:   if (tmr_done) state_d = S_AHOLD;
      S_AHOLD: if (tmr_done) state_d = S_GAP;
      S_GAP:   if (tmr_done) state_d = S_DSET;
      S_DSET:  if (tmr_done) state_d = S_DSTB;
      S_DSTB:  if (tmr_done) state_d = S_DHOLD;
      S_DHOLD: if (tmr_done) state_d = S_DONE;
      S_DONE:  state_d = init0_q ? S_INIT1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every state change reloads the timer with the length of the phase being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_len  = 8'd1;
    case (state_d)
      S_ADDR, S_DSET:          tmr_len = LEN_SETUP;
      S_AWR, S_DSTB:           tmr_len = LEN_PULSE;
      S_AHOLD, S_GAP, S_DHOLD: tmr_len = LEN_HOLD;
      default:                 tmr_len = 8'd1;
    endcase
  end

  // Bus pins are registered from the next state so they change glitch-free with state_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_INIT0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      wr_q      <= 1'b0;
      init0_q   <= 1'b1;
      frw_q     <= 1'b0;
      dato_rd_q <= 8'h00;
      bus_q     <= BUS_IDLE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      init0_q <= init0_d;
      frw_q   <= (state_d == S_DONE) && !init0_d;
      bus_q   <= bus_decode(state_d, wr_d, addr_d, data_d);
      if (state_q == S_DSTB && tmr_done && !wr_q) dato_rd_q <= AD_in;
    end
  end

  assign FRW     = frw_q;
  assign Dato_rd = dato_rd_q;
  assign CS_n    = bus_q.cs_n;
  assign RD_n    = bus_q.rd_n;
  assign WR_n    = bus_q.wr_n;
  assign A_D     = bus_q.a_d;
  assign AD_out  = bus_q.ad;
  assign AD_oe   = bus_q.oe;

endmodule

// File: tb/tb_rtc_bus_controller.sv
// tb/tb_rtc_bus_controller.sv - bench comparing the RTC bus controller against a per-cycle expectation queue
module tb_rtc_bus_controller;

  localparam int         T_SETUP = 2;
  localparam int         T_PULSE = 4;
  localparam int         T_HOLD  = 2;
  localparam logic [7:0] I_ADDR  = 8'h02;
  localparam logic [7:0] I_V0    = 8'h10;
  localparam logic [7:0] I_V1    = 8'h00;

  logic       CLK = 1'b0;
  logic       RST, Acceso, Mod, FRW, CS_n, RD_n, WR_n, A_D, AD_oe;
  logic [6:0] Dir;
  logic [7:0] Dato_wr, Dato_rd, AD_out, AD_in;

  rtc_bus_controller #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
    .INIT_ADDR(I_ADDR), .INIT_V0(I_V0), .INIT_V1(I_V1)
  ) dut (
    .CLK(CLK), .RST(RST), .Acceso(Acceso), .Dir(Dir), .Mod(Mod), .Dato_wr(Dato_wr),
    .FRW(FRW), .Dato_rd(Dato_rd), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A_D(A_D),
    .AD_out(AD_out), .AD_oe(AD_oe), .AD_in(AD_in)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       cs_n, rd_n, wr_n, a_d, oe;
    logic [7:0] ad;
    logic       frw, smp;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic       cur_idle;
  logic [7:0] exp_dato;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;

  function automatic exp_t mk(input logic cs_n, rd_n, wr_n, a_d, oe,
                              input logic [7:0] ad, input logic frw, smp);
    exp_t e;
    e = '{cs_n: cs_n, rd_n: rd_n, wr_n: wr_n, a_d: a_d, oe: oe, ad: ad, frw: frw, smp: smp};
    return e;
  endfunction

  function automatic exp_t idle_cycle(input logic frw);
    return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, frw, 1'b0);
  endfunction

  // One complete access as a list of expected per-cycle bus values.
  task automatic push_txn(input logic [7:0] a, input logic w, input logic [7:0] d, input logic f);
    logic [7:0] dv;
    dv = w ? d : 8'h00;
    for (int i = 0; i < T_SETUP; i++) q.push_back(mk(0, 1, 1, 0, 1, a, 0, 0));
    for (int i = 0; i < T_PULSE; i++) q.push_back(mk(0, 1, 0, 0, 1, a, 0, 0));
    for (int i = 0; i < T_HOLD;  i++) q.push_back(mk(0, 1, 1, 0, 1, a, 0, 0));
    for (int i = 0; i < T_HOLD;  i++) q.push_back(idle_cycle(1'b0));
    for (int i = 0; i < T_SETUP; i++) q.push_back(mk(0, 1, 1, 1, w, dv, 0, 0));
    for (int i = 0; i < T_PULSE; i++)
      q.push_back(mk(0, w, !w, 1, w, dv, 0, (!w && i == T_PULSE - 1)));
    for (int i = 0; i < T_HOLD;  i++) q.push_back(mk(0, 1, 1, 1, w, dv, 0, 0));
    q.push_back(idle_cycle(f));
  endtask

  task automatic model_edge();
    if (RST) begin
      q.delete();
      exp_dato = 8'h00;
      q.push_back(idle_cycle(1'b0));
      push_txn(I_ADDR, 1'b1, I_V0, 1'b0);
      q.push_back(idle_cycle(1'b0));
      push_txn(I_ADDR, 1'b1, I_V1, 1'b1);
    end else begin
      if (cur.smp) exp_dato = AD_in;
      if (cur_idle && Acceso) push_txn({1'b0, Dir}, Mod, Dato_wr, 1'b1);
    end
    if (q.size() > 0) begin
      cur = q.pop_front();
      cur_idle = 1'b0;
    end else begin
      cur = idle_cycle(1'b0);
      cur_idle = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare();
    chk("cs_n",  {7'd0, CS_n},  {7'd0, cur.cs_n});
    chk("rd_n",  {7'd0, RD_n},  {7'd0, cur.rd_n});
    chk("wr_n",  {7'd0, WR_n},  {7'd0, cur.wr_n});
    chk("a_d",   {7'd0, A_D},   {7'd0, cur.a_d});
    chk("ad_oe", {7'd0, AD_oe}, {7'd0, cur.oe});
    if (cur.oe) chk("ad_out", AD_out, cur.ad);
    chk("frw",     {7'd0, FRW}, {7'd0, cur.frw});
    chk("dato_rd", Dato_rd, exp_dato);
    chk("no_contention", {7'd0, AD_oe & ~RD_n}, 8'h00);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    cyc++;
    compare();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !cur_idle; i++) step();
  endtask

  initial begin
    cur = idle_cycle(1'b0);
    cur_idle = 1'b0;
    exp_dato = 8'h00;
    RST = 1'b1; Acceso = 1'b0; Dir = 7'h00; Mod = 1'b0; Dato_wr = 8'h00; AD_in = 8'h00;

    // Reset then the two init writes and the init-done pulse.
    repeat (3) step();
    RST = 1'b0;
    repeat (45) step();
    wait_idle();

    // Directed read of register 21 returning 45.
    AD_in = 8'h45; Dir = 7'h21; Mod = 1'b0; Acceso = 1'b1;
    step();
    Acceso = 1'b0; Dir = 7'h7f;
    repeat (21) step();

    // Directed write 41 <- 30; Dato_rd must keep 45.
    Dir = 7'h41; Mod = 1'b1; Dato_wr = 8'h30; Acceso = 1'b1;
    step();
    Acceso = 1'b0; Dato_wr = 8'hee; Mod = 1'b0;
    repeat (21) step();

    // Second request mid-transaction is dropped.
    AD_in = 8'h9a; Dir = 7'h33; Mod = 1'b0; Acceso = 1'b1;
    step();
    Acceso = 1'b0;
    repeat (4) step();
    Dir = 7'h55; Mod = 1'b1; Acceso = 1'b1;
    step();
    Acceso = 1'b0;
    repeat (22) step();

    // Reset during the read strobe aborts and restarts init.
    AD_in = 8'hc3; Dir = 7'h12; Mod = 1'b0; Acceso = 1'b1;
    step();
    Acceso = 1'b0;
    repeat (13) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (45) step();
    wait_idle();

    // Acceso held high: back-to-back accesses with changing inputs.
    Acceso = 1'b1;
    for (int i = 0; i < 62; i++) begin
      Dir = 7'($urandom); Mod = 1'($urandom); Dato_wr = 8'($urandom); AD_in = 8'($urandom);
      step();
    end
    Acceso = 1'b0;
    repeat (22) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      Acceso  = ($urandom_range(0, 3) == 0);
      Dir     = 7'($urandom);
      Mod     = 1'($urandom);
      Dato_wr = 8'($urandom);
      AD_in   = 8'($urandom);
      RST     = ($urandom_range(0, 249) == 0);
      step();
    end
    RST = 1'b0; Acceso = 1'b0;
    repeat (50) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
